// File: rtl/sram_req_arbiter.sv
// Arbitrates fetch and data requesters onto one SRAM-like port (data wins),
// tracking outstanding transactions in order so each response reaches its owner.
module sram_req_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        inst_cancel,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StHoldI, StHoldD} state_e;

   state_e           state_q;
   logic [PTR_W-1:0] head_q, tail_q;
   logic [PTR_W:0]   count_q;
   logic [DEPTH-1:0] owner_q;    // 1 = data, 0 = inst
   logic [DEPTH-1:0] discard_q;
   logic [DEPTH-1:0] entry_valid;

   logic grant_inst, grant_data, full, push, pop, head_owner, head_discard;

   always_comb begin
      grant_data = (state_q == StHoldD) || ((state_q == StIdle) && data_req);
      grant_inst = (state_q == StHoldI) || ((state_q == StIdle) && !data_req && inst_req);
      full       = (count_q == (PTR_W+1)'(DEPTH));
      mem_req    = resetn && !full && (grant_data ? data_req : (grant_inst && inst_req));
      push       = mem_req && mem_addr_ok;
      pop        = resetn && mem_data_ok && (count_q != '0);
      head_owner   = owner_q[head_q];
      head_discard = discard_q[head_q];
   end

   // An entry is live when its distance from the head is below the count.
   always_comb begin
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_valid[i] = {1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q;
      end
   end

   always_comb begin
      if (grant_data) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_addr  = data_addr;
         mem_wstrb = data_wstrb;
         mem_wdata = data_wdata;
      end else begin
         mem_wr    = 1'b0;
         mem_size  = 2'd2;
         mem_addr  = inst_addr;
         mem_wstrb = 4'b0000;
         mem_wdata = 32'h0;
      end
   end

   assign inst_addr_ok = grant_inst && push;
   assign data_addr_ok = grant_data && push;
   // A cancel in the same cycle as the pop also suppresses the head fetch.
   assign inst_data_ok = pop && !head_owner && !head_discard && !inst_cancel;
   assign data_data_ok = pop && head_owner;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         owner_q   <= '0;
         discard_q <= '0;
      end else begin
         unique case (state_q)
            StIdle:  if (mem_req && !mem_addr_ok) state_q <= grant_data ? StHoldD : StHoldI;
            StHoldI: if (mem_addr_ok || !inst_req) state_q <= StIdle;
            StHoldD: if (mem_addr_ok || !data_req) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         for (int i = 0; i < DEPTH; i++) begin
            if (inst_cancel && entry_valid[i] && !owner_q[i]) discard_q[i] <= 1'b1;
         end

         if (push) begin
            owner_q[tail_q]   <= grant_data;
            discard_q[tail_q] <= !grant_data && inst_cancel;
            tail_q            <= tail_q + PTR_W'(1);
         end
         if (pop) head_q <= head_q + PTR_W'(1);

         if (push && !pop) count_q <= count_q + (PTR_W+1)'(1);
         else if (!push && pop) count_q <= count_q - (PTR_W+1)'(1);
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter; responses are checked by a scoreboard monitor.
module tb_sram_req_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_addr_ok, inst_data_ok, inst_cancel;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   sram_req_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic        owner;   // 1 = data
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endfunction

   // Responses are zero-latency, so each expected entry must be answered in its own cycle.
   always @(negedge clk) begin
      if (inst_data_ok || data_data_ok) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got inst_data_ok=%b data_data_ok=%b, required none",
                     inst_data_ok, data_data_ok);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_both", 32'(inst_data_ok & data_data_ok), 32'd0);
            chk("resp_owner", 32'(data_data_ok), 32'(mon_e.owner));
            chk("resp_rdata", mon_e.owner ? data_rdata : inst_rdata, mon_e.rdata);
         end
      end else if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_resp: got no data_ok, required owner=%0d rdata=%h",
                  mon_e.owner, mon_e.rdata);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic is_data, input logic [31:0] addr);
      inst_req    = !is_data;
      data_req    = is_data;
      inst_addr   = addr;
      data_addr   = addr;
      mem_addr_ok = 1'b1;
      #2;
      chk("issue_addr_ok", 32'(is_data ? data_addr_ok : inst_addr_ok), 32'd1);
      chk("issue_mem_addr", mem_addr, addr);
      tick();
      inst_req = 1'b0;
      data_req = 1'b0;
   endtask

   task automatic respond(input logic [31:0] rd, input logic expect_resp, input logic owner);
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      if (expect_resp) exp_q.push_back({owner, rd});
      tick();
      mem_data_ok = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_cancel = 1'b0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
      data_wstrb = 4'h0; data_wdata = 32'h0;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hdead_beef;

      // Reset forces the handshake outputs low even with memory strobes high.
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("rst_mem_req", 32'(mem_req), 32'd0);
         chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
         chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
         tick();
      end
      resetn = 1'b1; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      #2;
      chk("idle_mem_req", 32'(mem_req), 32'd1);
      chk("idle_mem_addr", mem_addr, 32'h1c00_0000);
      chk("idle_mem_wr", 32'(mem_wr), 32'd0);
      chk("idle_mem_size", 32'(mem_size), 32'd2);
      tick();
      inst_req = 1'b0;
      tick();

      // Contention: data wins, inst follows once data withdraws.
      inst_req = 1'b1; inst_addr = 32'h1c00_0100;
      data_req = 1'b1; data_addr = 32'h1c00_00f0; mem_addr_ok = 1'b1;
      #2;
      chk("cont_data_addr_ok", 32'(data_addr_ok), 32'd1);
      chk("cont_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      chk("cont_mem_addr", mem_addr, 32'h1c00_00f0);
      tick();
      data_req = 1'b0;
      #2;
      chk("cont_inst_after", 32'(inst_addr_ok), 32'd1);
      chk("cont_mem_addr2", mem_addr, 32'h1c00_0100);
      tick();
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      respond(32'hd0d0_0001, 1'b1, 1'b1);
      respond(32'h1111_0002, 1'b1, 1'b0);

      // Hold: stalled inst address phase is not pre-empted by a later data request.
      inst_req = 1'b1; inst_addr = 32'h1c00_0200;
      #2;
      chk("hold_inst_addr_ok0", 32'(inst_addr_ok), 32'd0);
      tick();
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1c00_0300; data_size = 2'd0;
      data_wstrb = 4'b0100; data_wdata = 32'h00ab_0000;
      #2;
      chk("hold_mem_addr", mem_addr, 32'h1c00_0200);
      chk("hold_mem_wr", 32'(mem_wr), 32'd0);
      chk("hold_data_addr_ok0", 32'(data_addr_ok), 32'd0);
      tick();
      mem_addr_ok = 1'b1;
      #2;
      chk("hold_inst_accept", 32'(inst_addr_ok), 32'd1);
      chk("hold_data_wait", 32'(data_addr_ok), 32'd0);
      tick();
      inst_req = 1'b0;
      #2;
      chk("hold_data_accept", 32'(data_addr_ok), 32'd1);
      chk("hold_data_addr", mem_addr, 32'h1c00_0300);
      chk("hold_data_wr", 32'(mem_wr), 32'd1);
      chk("hold_data_size", 32'(mem_size), 32'd0);
      chk("hold_data_wstrb", 32'(mem_wstrb), 32'h4);
      chk("hold_data_wdata", mem_wdata, 32'h00ab_0000);
      tick();
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
      mem_addr_ok = 1'b0;
      respond(32'h2222_0000, 1'b1, 1'b0);
      respond(32'h3333_0000, 1'b1, 1'b1);

      // Full queue: fifth request blocked, no bypass on the popping cycle.
      issue(1'b0, 32'h1c00_1000);
      issue(1'b1, 32'h1c00_1004);
      issue(1'b0, 32'h1c00_1008);
      issue(1'b1, 32'h1c00_100c);
      inst_req = 1'b1; inst_addr = 32'h1c00_1010;
      #2;
      chk("full_mem_req", 32'(mem_req), 32'd0);
      chk("full_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      tick();
      mem_data_ok = 1'b1; mem_rdata = 32'h0000_00f0;
      exp_q.push_back({1'b0, 32'h0000_00f0});
      #2;
      chk("full_no_bypass", 32'(mem_req), 32'd0);
      tick();
      mem_data_ok = 1'b0;
      #2;
      chk("full_reopen_req", 32'(mem_req), 32'd1);
      chk("full_reopen_ok", 32'(inst_addr_ok), 32'd1);
      tick();
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      respond(32'h0000_00f1, 1'b1, 1'b1);
      respond(32'h0000_00f2, 1'b1, 1'b0);
      respond(32'h0000_00f3, 1'b1, 1'b1);
      respond(32'h0000_00f4, 1'b1, 1'b0);

      // Cancel: outstanding fetches are dropped, data survives, new fetch is normal.
      issue(1'b0, 32'h1c00_0400);
      issue(1'b1, 32'h1c00_0500);
      issue(1'b0, 32'h1c00_0404);
      mem_addr_ok = 1'b0; inst_cancel = 1'b1;
      tick();
      inst_cancel = 1'b0;
      respond(32'h0000_000a, 1'b0, 1'b0);
      respond(32'h0000_000b, 1'b1, 1'b1);
      respond(32'h0000_000c, 1'b0, 1'b0);
      issue(1'b0, 32'h1c00_0408);
      mem_addr_ok = 1'b0;
      respond(32'h0000_000d, 1'b1, 1'b0);

      // Cancel coinciding with a push and with the head pop: both fetches dropped.
      issue(1'b0, 32'h1c00_0410);
      inst_req = 1'b1; inst_addr = 32'h1c00_0414; mem_addr_ok = 1'b1;
      inst_cancel = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_000e;
      #2;
      chk("cancel_push_ok", 32'(inst_addr_ok), 32'd1);
      tick();
      inst_req = 1'b0; inst_cancel = 1'b0; mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
      respond(32'h0000_000f, 1'b0, 1'b0);
      issue(1'b1, 32'h1c00_0600);
      mem_addr_ok = 1'b0;
      respond(32'h0000_0099, 1'b1, 1'b1);

      // Stray response on an empty queue leaves the count at zero.
      respond(32'h0000_0bad, 1'b0, 1'b0);
      issue(1'b1, 32'h1c00_2000);
      issue(1'b0, 32'h1c00_2004);
      issue(1'b1, 32'h1c00_2008);
      issue(1'b0, 32'h1c00_200c);
      data_req = 1'b1; data_addr = 32'h1c00_2010;
      #2;
      chk("stray_full_req", 32'(mem_req), 32'd0);
      tick();
      data_req = 1'b0; mem_addr_ok = 1'b0;
      respond(32'h0000_0c01, 1'b1, 1'b1);
      respond(32'h0000_0c02, 1'b1, 1'b0);
      respond(32'h0000_0c03, 1'b1, 1'b1);
      respond(32'h0000_0c04, 1'b1, 1'b0);

      tick();
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
